// File: rtl/si_cmd_sequencer_pkg.sv
// Shared state encodings and parameter defaults for the SI command sequencer.
// Byte-to-register-write path; no datapath latency of its own.
package si_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } si_state_t;

  localparam int SI_ADDR_WIDTH      = 8;
  localparam int SI_DATA_WIDTH      = 8;
  localparam int SI_TIMEOUT_CYCLES  = 16;

endpackage

// File: rtl/si_ack_timer.sv
// Counts write cycles without acknowledge; done fires on the cycle the count would reach TIMEOUT_CYCLES.
// Combinational done from en and count; no backpressure.
module si_ack_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  // done looks one cycle ahead so the abort lands exactly TIMEOUT_CYCLES cycles after entry
  assign done = en && (count == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/si_cmd_sequencer.sv
// Turns address/data byte pairs into SI register writes; rdy rises on the data-byte edge, drops on ack edge.
// Bytes stall at the source (in_ack=0) while a write is outstanding. Optional ack timeout: SI_ACK_TIMEOUT_EN.
import si_cmd_sequencer_pkg::*;

module si_cmd_sequencer #(
  parameter int ADDR_WIDTH     = SI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = SI_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_rdy,
  output logic                  in_ack,
  output logic [ADDR_WIDTH-1:0] register_addr,
  output logic [DATA_WIDTH-1:0] register_data,
  output logic                  register_rdy,
  input  logic                  register_ack,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  if (ADDR_WIDTH > 8 || DATA_WIDTH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("si_cmd_sequencer: parameter out of range");
  end

  si_state_t state;
  logic      timeout;

  assign in_ack = (state == S_ADDR) || (state == S_DATA);
  assign busy   = (state != S_ADDR);

`ifdef SI_ACK_TIMEOUT_EN
  si_ack_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == S_DATA) && in_rdy),
    .en   (state == S_WRITE),
    .done (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_ADDR;
      register_addr <= '0;
      register_data <= '0;
      register_rdy  <= 1'b0;
      wr_done       <= 1'b0;
      err           <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      // clear first so a same-cycle timeout set overrides it
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        S_ADDR: begin
          if (in_rdy) begin
            register_addr <= in_data[ADDR_WIDTH-1:0];
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (in_rdy) begin
            register_data <= in_data[DATA_WIDTH-1:0];
            register_rdy  <= 1'b1;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (register_ack) begin
            register_rdy <= 1'b0;
            wr_done      <= 1'b1;
            state        <= S_ADDR;
          end else if (timeout) begin
            register_rdy <= 1'b0;
            err          <= 1'b1;
            state        <= S_ADDR;
          end
        end
        default: begin
          register_rdy <= 1'b0;
          state        <= S_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_si_cmd_sequencer.sv
// Directed bench for si_cmd_sequencer with a write scoreboard; covers both SI_ACK_TIMEOUT_EN builds.
`timescale 1ns/1ps
module tb_si_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_rdy;
  logic       in_ack;
  logic [7:0] register_addr;
  logic [7:0] register_data;
  logic       register_rdy;
  logic       register_ack;
  logic       wr_done;
  logic       busy;
  logic       err;
  logic       err_clr;

  si_cmd_sequencer #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_rdy        (in_rdy),
    .in_ack        (in_ack),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .register_ack  (register_ack),
    .wr_done       (wr_done),
    .busy          (busy),
    .err           (err),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  rdy_len  = 0;
  int  last_rdy_len = 0;
  int  done_cnt = 0;
  logic rdy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rising register_rdy must match the next expected write.
  always @(negedge clk) begin
    wr_t cur;
    if (register_rdy && !rdy_prev) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("sb_addr", 32'(register_addr), 32'(cur.a));
        chk("sb_data", 32'(register_data), 32'(cur.d));
      end
      rdy_len = 0;
    end
    if (register_rdy) rdy_len++;
    if (!register_rdy && rdy_prev) last_rdy_len = rdy_len;
    if (wr_done) done_cnt++;
    rdy_prev = register_rdy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken = 0;
    in_data = b;
    in_rdy  = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      if (in_ack) taken = 1;
      step();
    end
    in_rdy = 1'b0;
    chk("byte_accepted", 32'(taken), 32'd1);
  endtask

  task automatic finish_write(input int delay);
    for (int i = 0; i < delay; i++) step();
    register_ack = 1'b1;
    step();
    chk("ack_rdy_low", 32'(register_rdy), 32'd0);
    chk("ack_wr_done", 32'(wr_done), 32'd1);
    chk("ack_busy_low", 32'(busy), 32'd0);
    register_ack = 1'b0;
    step();
    chk("wr_done_pulse_end", 32'(wr_done), 32'd0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; in_data = 8'h00; in_rdy = 1'b0; register_ack = 1'b0; err_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_addr", 32'(register_addr), 32'h0);
    chk("rst_data", 32'(register_data), 32'h0);
    chk("rst_rdy", 32'(register_rdy), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ack", 32'(in_ack), 32'd1);

    // 1: ack two cycles after rdy
    exp_q.push_back('{a: 8'h03, d: 8'hA5});
    send_byte(8'h03);
    chk("t1_busy_after_addr", 32'(busy), 32'd1);
    send_byte(8'hA5);
    chk("t1_rdy", 32'(register_rdy), 32'd1);
    chk("t1_in_ack_low", 32'(in_ack), 32'd0);
    finish_write(1);
    chk("t1_rdy_len", 32'(last_rdy_len), 32'd2);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: ack already high; ignored outside S_WRITE
    register_ack = 1'b1;
    exp_q.push_back('{a: 8'h10, d: 8'h3C});
    send_byte(8'h10);
    chk("t2_no_rdy_in_data", 32'(register_rdy), 32'd0);
    chk("t2_wr_done_quiet", 32'(wr_done), 32'd0);
    send_byte(8'h3C);
    chk("t2_rdy", 32'(register_rdy), 32'd1);
    step();
    chk("t2_rdy_low", 32'(register_rdy), 32'd0);
    chk("t2_wr_done", 32'(wr_done), 32'd1);
    register_ack = 1'b0;
    step();
    chk("t2_wr_done_end", 32'(wr_done), 32'd0);
    chk("t2_rdy_len", 32'(last_rdy_len), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);

    // 4: third byte held during S_WRITE
    exp_q.push_back('{a: 8'h21, d: 8'h5A});
    exp_q.push_back('{a: 8'h07, d: 8'h6B});
    send_byte(8'h21);
    send_byte(8'h5A);
    in_data = 8'h07;
    in_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_in_ack_low", 32'(in_ack), 32'd0);
      chk("t4_addr_stable", 32'(register_addr), 32'h21);
      chk("t4_data_stable", 32'(register_data), 32'h5A);
      step();
    end
    register_ack = 1'b1;
    step();
    chk("t4_rdy_low", 32'(register_rdy), 32'd0);
    chk("t4_wr_done", 32'(wr_done), 32'd1);
    register_ack = 1'b0;
    chk("t4_in_ack_back", 32'(in_ack), 32'd1);
    step();
    in_rdy = 1'b0;
    chk("t4_next_addr", 32'(register_addr), 32'h07);
    chk("t4_busy", 32'(busy), 32'd1);
    send_byte(8'h6B);
    finish_write(1);

    // 5: reset mid-command discards the address
    send_byte(8'h05);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_addr_after_rst", 32'(register_addr), 32'h0);
    exp_q.push_back('{a: 8'h09, d: 8'h22});
    send_byte(8'h09);
    send_byte(8'h22);
    chk("t5_addr", 32'(register_addr), 32'h09);
    finish_write(0);

    // reset during S_WRITE drops rdy at that edge
    exp_q.push_back('{a: 8'h33, d: 8'h44});
    send_byte(8'h33);
    send_byte(8'h44);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_in_write_rdy", 32'(register_rdy), 32'd0);
    chk("rst_in_write_busy", 32'(busy), 32'd0);
    step();

`ifdef SI_ACK_TIMEOUT_EN
    // 3: never acked -> timeout
    dc = done_cnt;
    exp_q.push_back('{a: 8'hFF, d: 8'h11});
    send_byte(8'hFF);
    send_byte(8'h11);
    for (int i = 0; i < 40 && register_rdy; i++) step();
    step();
    chk("t3_rdy_len", 32'(last_rdy_len), 32'd16);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_no_wr_done", 32'(done_cnt), 32'(dc));
    chk("t3_busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_err_cleared", 32'(err), 32'd0);

    // 6: ack on the final cycle wins
    exp_q.push_back('{a: 8'h42, d: 8'h99});
    send_byte(8'h42);
    send_byte(8'h99);
    finish_write(15);
    chk("t6_rdy_len", 32'(last_rdy_len), 32'd16);
    chk("t6_err", 32'(err), 32'd0);
`else
    // 6: no timeout, long wait still completes
    dc = done_cnt;
    exp_q.push_back('{a: 8'h42, d: 8'h99});
    send_byte(8'h42);
    send_byte(8'h99);
    finish_write(100);
    chk("t6_rdy_len", 32'(last_rdy_len), 32'd101);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_done_cnt", 32'(done_cnt), 32'(dc + 1));
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
